// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//   Pipeline hazard controller. It combines three sources of pipeline control:
//   per-stage level stall requests, a timed multi-cycle hold (mul/div, cache
//   refill) and a registered flush/redirect (exception, mispredict). From these
//   it drives per-stage stall and bubble vectors and the redirect PC for IF.
//   Stage 0 is the PC register and stage NSTAGE-1 is WB. NSTAGE must be >= 2.
//
// Ports
//   clk        in   1            clock, all state on the rising edge
//   rst        in   1            synchronous reset, active-low
//   stallreq   in   NSTAGE       level request, bit k = stage k cannot advance
//   hold_req   in   1            one-cycle pulse that starts a timed hold
//   hold_stage in   HSW          stage that owns the timed hold
//   hold_len   in   CNTW         hold length in cycles (0 is treated as 1)
//   flush_req  in   1            one-cycle pulse requesting a pipeline flush
//   flush_pc   in   PCW          redirect target, sampled with flush_req
//   stall      out  NSTAGE       stall[i]=1: stage i holds its register
//   bubble     out  NSTAGE       bubble[i]=1: stage i loads a NOP
//   flush      out  1            flush active
//   new_pc     out  PCW          redirect PC, valid while flush=1
//   busy       out  1            controller is in HOLD or FLUSH
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int NSTAGE    = 6,
    parameter int CNTW      = 6,
    parameter int FLUSH_CYC = 1,
    parameter int PCW       = 32,
    localparam int HSW      = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              hold_req,
    input  logic [HSW-1:0]    hold_stage,
    input  logic [CNTW-1:0]   hold_len,
    input  logic              flush_req,
    input  logic [PCW-1:0]    flush_pc,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] bubble,
    output logic              flush,
    output logic [PCW-1:0]    new_pc,
    output logic              busy
);

    localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNTW-1:0]   cnt_r;
    logic [CNTW-1:0]   cnt_s;
    logic [FCW-1:0]    fcnt_r;
    logic [FCW-1:0]    fcnt_s;
    logic [PCW-1:0]    new_pc_r;
    logic [PCW-1:0]    new_pc_s;
    logic [HSW-1:0]    hold_stage_r;
    logic [HSW-1:0]    hold_stage_s;
    logic              hold_act_s;
    logic [HSW-1:0]    hstage_s;
    logic [NSTAGE-1:0] req_s;
    logic [NSTAGE-1:0] mask_s;

    // One-hot decode of a stage index; indices at or above NSTAGE decode to nothing.
    function automatic logic [NSTAGE-1:0] stage_onehot(input logic [HSW-1:0] idx);
        logic [NSTAGE-1:0] oh;
        oh = {NSTAGE{1'b0}};
        for (int i = 0; i < NSTAGE; i++) begin
            if (idx == HSW'(i)) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // Suffix-OR: bit i is set when any request at stage i or above is set,
    // which is exactly stall[k:0] for the highest requesting stage k.
    function automatic logic [NSTAGE-1:0] stall_mask(input logic [NSTAGE-1:0] req);
        logic [NSTAGE-1:0] m;
        logic              acc;
        acc = 1'b0;
        m   = {NSTAGE{1'b0}};
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc  = acc | req[i];
            m[i] = acc;
        end
        return m;
    endfunction

    // State, hold counter, flush counter, latched hold owner and redirect PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNTW{1'b0}};
            fcnt_r       <= {FCW{1'b0}};
            new_pc_r     <= {PCW{1'b0}};
            hold_stage_r <= {HSW{1'b0}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            fcnt_r       <= fcnt_s;
            new_pc_r     <= new_pc_s;
            hold_stage_r <= hold_stage_s;
        end
    end

    // Next-state logic; also decides whether the timed hold contributes this cycle.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        fcnt_s       = fcnt_r;
        new_pc_s     = new_pc_r;
        hold_stage_s = hold_stage_r;
        hold_act_s   = 1'b0;
        hstage_s     = hold_stage_r;
        case (state_r)
            IDLE: begin
                if (flush_req) begin
                    state_s  = FLUSH;
                    new_pc_s = flush_pc;
                    fcnt_s   = {FCW{1'b0}};
                    cnt_s    = {CNTW{1'b0}};
                end else if (hold_req) begin
                    // The request cycle itself is hold cycle 1, so only lengths
                    // of 2 or more need the HOLD state.
                    hold_act_s   = 1'b1;
                    hstage_s     = hold_stage;
                    hold_stage_s = hold_stage;
                    if (hold_len > CNTW'(1)) begin
                        state_s = HOLD;
                        cnt_s   = hold_len - CNTW'(1);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD: begin
                // The hold still stalls in the cycle a flush is requested; the
                // flush itself takes effect one cycle later.
                hold_act_s = 1'b1;
                if (flush_req) begin
                    state_s  = FLUSH;
                    new_pc_s = flush_pc;
                    fcnt_s   = {FCW{1'b0}};
                    cnt_s    = {CNTW{1'b0}};
                end else if (cnt_r == CNTW'(1)) begin
                    state_s = IDLE;
                    cnt_s   = {CNTW{1'b0}};
                end else begin
                    cnt_s = cnt_r - CNTW'(1);
                end
            end
            FLUSH: begin
                if (flush_req) begin
                    new_pc_s = flush_pc;
                    fcnt_s   = {FCW{1'b0}};
                end else if (fcnt_r == FCW'(FLUSH_CYC - 1)) begin
                    state_s = IDLE;
                    fcnt_s  = {FCW{1'b0}};
                end else begin
                    fcnt_s = fcnt_r + FCW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNTW{1'b0}};
                fcnt_s  = {FCW{1'b0}};
            end
        endcase
    end

    // Merge level requests with the timed hold and form the stall mask.
    always_comb begin
        req_s = stallreq;
        if (hold_act_s) begin
            req_s = stallreq | stage_onehot(hstage_s);
        end else begin
            req_s = stallreq;
        end
        mask_s = stall_mask(req_s);
    end

    // Output drive: reset forces everything low, flush overrides stall requests.
    always_comb begin
        stall  = {NSTAGE{1'b0}};
        bubble = {NSTAGE{1'b0}};
        flush  = 1'b0;
        busy   = 1'b0;
        if (!rst) begin
            stall  = {NSTAGE{1'b0}};
            bubble = {NSTAGE{1'b0}};
        end else if (state_r == FLUSH) begin
            flush = 1'b1;
            busy  = 1'b1;
            for (int i = 1; i < NSTAGE; i++) begin
                bubble[i] = 1'b1;
            end
        end else begin
            busy  = (state_r != IDLE);
            stall = mask_s;
            // A bubble enters the stage just above the highest stalled one.
            for (int i = 1; i < NSTAGE; i++) begin
                bubble[i] = mask_s[i-1] & ~mask_s[i];
            end
        end
    end

    assign new_pc = new_pc_r;

endmodule
